nova_io_pio_timer: RTL and testbench
====================================

// Module: nova_io_pio_timer
// PURPOSE
//  Programmed-I/O interval-timer device on the Nova PIO device bus (bs_*). It is the responder
//  side of that bus: it decodes strobes for its own device code, executes DOA/DOB/DOC and the
//  start/clear/pulse controls, and returns DIA/DIB/DIC and flag-read data on bs_dout.
//  A prescaled down-counter sets DONE at terminal count and raises an interrupt request.
// PARAMETERS
//  DEV_CODE  6'o21  device code matched against bs_adr[0:5]
//  CNT_W     16     interval counter width (<=16, data zero-extended on reads)
//  PRE_W     16     prescaler width (<=16)
// PORTS
//  pclk     in   1   bus/system clock, all state on posedge
//  prst     in   1   reset, asynchronous, active-low
//  bs_stb   in   1   bus strobe, one pclk cycle per transfer
//  bs_we    in   1   1 = output (DOx/control), 0 = input (DIx/flag read)
//  bs_adr   in   8   [0:5] device code, [6:7] register select (00 ctl/flag, 01 A, 10 B, 11 C)
//  bs_din   in   16  write data, bit 0 = MSB; control code in bs_din[14:15]
//  bs_dout  out  16  read data, bit 0 = MSB; 0 when not returning a read
//  intr     out  1   interrupt request = done & int_en
// BEHAVIOUR
//  Reset (prst=0, async): busy=0, done=0, int_en=0, reload_a=0, reload_b=0, cnt=0, pre=0,
//   bs_dout=0, intr=0. Reset mid-count aborts immediately; no done is generated.
//  Hit = bs_stb & (bs_adr[0:5]==DEV_CODE). No hit -> no state change, bs_dout=0 next cycle.
//  Write hit, sel 00, bs_din[14:15]: 00 no-op; 01 START: cnt<=reload_a, pre<=reload_b,
//   busy<=1, done<=0; 10 CLEAR: busy<=0, done<=0, cnt/pre frozen; 11 PULSE: done<=0 only.
//  Write hit, sel 01: reload_a<=bs_din; sel 10: reload_b<=bs_din; sel 11: int_en<=bs_din[15].
//   Reload writes while busy affect only the next START; running cnt/pre are untouched.
//  Read hit: registered, bs_dout valid exactly the cycle after the strobe, 0 otherwise.
//   sel 00 flag read: bs_dout[14]=busy, [15]=done, rest 0. sel 01 DIA: current cnt.
//   sel 10 DIB: current pre. sel 11 DIC: {13'b0, int_en, busy, done}.
//  Counting (busy=1, no control write this cycle): if pre==0 then pre<=reload_b and tick,
//   else pre<=pre-1. So one tick every reload_b+1 cycles.
//  On tick: cnt<=cnt-1 (mod 2^CNT_W). If cnt==1 at tick -> cnt<=0, busy<=0, done<=1.
//   reload_a==0 therefore gives 2^CNT_W ticks (wraps through all ones).
//  Simultaneous: START/CLEAR/PULSE in same cycle as terminal tick -> the control write wins.
//   Terminal tick also sets done while PULSE is absent; PULSE in that cycle leaves done=0.
//   A read in the terminal cycle returns pre-update values (busy=1, done=0).
//  intr registered: intr = done & int_en, one cycle after either changes. It holds until
//   PULSE, CLEAR, START or int_en cleared.
//  Latency: control/register writes take effect at the end of the strobe cycle. Read data
//   arrives 1 cycle after the strobe. done rises at the end of the terminal-tick cycle.
// STRUCTURE
//  Include nova_io_defs.vh (shared by all PIO devices): localparams SEL_CTL/SEL_A/SEL_B/SEL_C,
//   CTL_NOP/CTL_START/CTL_CLEAR/CTL_PULSE, and flag bit positions BIT_BUSY=14, BIT_DONE=15.
//  Sub-module nova_io_pio_decode (reused by other devices): device-code match and function
//   decode -> one-hot wr_a/wr_b/wr_c/rd_a/rd_b/rd_c/rd_flag/start/clear/pulse.
//  The timer core (prescaler, counter, flags, read mux) lives in this module.
// TESTING
//  Reset: prst=0 mid-count with cnt=5 -> all outputs 0 immediately, busy=done=0 after release.
//  DOA 0x0003, DOB 0x0001, START -> DIA reads 3,2,1 at 2-cycle ticks; done=1 exactly 6
//   cycles after START; flag read returns 0x0001.
//  DOC 0x0001 then run to done -> intr=1 one cycle after done. PULSE -> done=0, intr=0
//   next cycle, busy unaffected.
//  START issued in the terminal-tick cycle -> busy stays 1, done stays 0, cnt=reload_a.
//  reload_a=0, reload_b=0 -> done after exactly 65536 ticks. Strobe with device code 6'o22
//   -> no state change and bs_dout=0.
//  DOA 0x0010 while busy with cnt=7 -> run ends at 0. Next START loads 0x0010. CLEAR
//   mid-run freezes DIA value.

Source files
------------

// File: rtl/nova_io_pio_timer_pkg.sv
// Shared PIO bus definitions: widths, register selects, control codes, decoded-function bundle.
package nova_io_pio_timer_pkg;

    localparam int unsigned DEV_W  = 6;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CTL_W  = 2;
    localparam int unsigned ADR_W  = DEV_W + SEL_W;
    localparam int unsigned DATA_W = 16;

    // Flag bit positions in bus (bit 0 = MSB) numbering.
    localparam int unsigned BIT_BUSY = 14;
    localparam int unsigned BIT_DONE = 15;

    typedef enum logic [SEL_W-1:0] {
        SEL_CTL = 2'b00,
        SEL_A   = 2'b01,
        SEL_B   = 2'b10,
        SEL_C   = 2'b11
    } sel_e;

    typedef enum logic [CTL_W-1:0] {
        CTL_NOP   = 2'b00,
        CTL_START = 2'b01,
        CTL_CLEAR = 2'b10,
        CTL_PULSE = 2'b11
    } ctl_e;

    // One-hot decoded bus function for the current strobe.
    typedef struct packed {
        logic wr_a;
        logic wr_b;
        logic wr_c;
        logic rd_a;
        logic rd_b;
        logic rd_c;
        logic rd_flag;
        logic start;
        logic clear;
        logic pulse;
    } pio_fn_t;

endpackage

// File: rtl/nova_io_pio_timer_if.sv
// Nova PIO device bus; bit 0 is the MSB on address and data.
interface nova_io_pio_timer_if;
    import nova_io_pio_timer_pkg::*;

    logic              bs_stb;
    logic              bs_we;
    logic [0:ADR_W-1]  bs_adr;
    logic [0:DATA_W-1] bs_din;
    logic [0:DATA_W-1] bs_dout;

    modport master (output bs_stb, output bs_we, output bs_adr, output bs_din, input  bs_dout);
    modport slave  (input  bs_stb, input  bs_we, input  bs_adr, input  bs_din, output bs_dout);
endinterface

// File: rtl/nova_io_pio_timer_decode.sv
// Device-code match and PIO function decode, shared by PIO devices.
module nova_io_pio_decode
    import nova_io_pio_timer_pkg::*;
#(
    parameter logic [DEV_W-1:0] DEV_CODE = 6'o21
) (
    input  logic             bs_stb,
    input  logic             bs_we,
    input  logic [0:ADR_W-1] bs_adr,
    input  logic [CTL_W-1:0] ctl,
    output pio_fn_t          fn_c
);

    logic hit;
    sel_e sel;

    // Decode a strobe addressed to this device into one function strobe.
    always_comb begin
        fn_c = '0;
        hit  = bs_stb && (bs_adr[0:DEV_W-1] == DEV_CODE);
        sel  = sel_e'(bs_adr[DEV_W:ADR_W-1]);
        if (hit) begin
            if (bs_we) begin
                unique case (sel)
                    SEL_CTL: begin
                        fn_c.start = (ctl == CTL_START);
                        fn_c.clear = (ctl == CTL_CLEAR);
                        fn_c.pulse = (ctl == CTL_PULSE);
                    end
                    SEL_A:   fn_c.wr_a = 1'b1;
                    SEL_B:   fn_c.wr_b = 1'b1;
                    SEL_C:   fn_c.wr_c = 1'b1;
                    default: ;
                endcase
            end else begin
                unique case (sel)
                    SEL_CTL: fn_c.rd_flag = 1'b1;
                    SEL_A:   fn_c.rd_a    = 1'b1;
                    SEL_B:   fn_c.rd_b    = 1'b1;
                    SEL_C:   fn_c.rd_c    = 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/nova_io_pio_timer.sv
// Nova PIO interval timer: prescaled down-counter, done/busy flags, interrupt, register reads.
module nova_io_pio_timer
    import nova_io_pio_timer_pkg::*;
#(
    parameter logic [DEV_W-1:0] DEV_CODE = 6'o21,
    parameter int unsigned      CNT_W    = 16,
    parameter int unsigned      PRE_W    = 16
) (
    input  logic                pclk,
    input  logic                prst,
    nova_io_pio_timer_if.slave  bus,
    output logic                intr
);

    pio_fn_t fn_c;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              int_en_q, int_en_d;
    logic              intr_q, intr_d;
    logic [CNT_W-1:0]  reload_a_q, reload_a_d;
    logic [PRE_W-1:0]  reload_b_q, reload_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [0:DATA_W-1] dout_q, dout_d;

    nova_io_pio_decode #(.DEV_CODE(DEV_CODE)) u_decode (
        .bs_stb (bus.bs_stb),
        .bs_we  (bus.bs_we),
        .bs_adr (bus.bs_adr),
        .ctl    (bus.bs_din[DATA_W-CTL_W:DATA_W-1]),
        .fn_c   (fn_c)
    );

    // Next state: read mux on pre-update values, register writes, control, prescale/count.
    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        int_en_d   = int_en_q;
        reload_a_d = reload_a_q;
        reload_b_d = reload_b_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        dout_d     = '0;
        intr_d     = done_q & int_en_q;

        if (fn_c.rd_flag) begin
            dout_d[BIT_BUSY] = busy_q;
            dout_d[BIT_DONE] = done_q;
        end
        if (fn_c.rd_a) dout_d = DATA_W'(cnt_q);
        if (fn_c.rd_b) dout_d = DATA_W'(pre_q);
        if (fn_c.rd_c) dout_d = DATA_W'({int_en_q, busy_q, done_q});

        if (fn_c.wr_a) reload_a_d = CNT_W'(bus.bs_din);
        if (fn_c.wr_b) reload_b_d = PRE_W'(bus.bs_din);
        if (fn_c.wr_c) int_en_d   = bus.bs_din[DATA_W-1];

        // Control writes take priority over the count in the same cycle.
        if (fn_c.start) begin
            cnt_d  = reload_a_q;
            pre_d  = reload_b_q;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (fn_c.clear) begin
            busy_d = 1'b0;
            done_d = 1'b0;
        end else if (fn_c.pulse) begin
            done_d = 1'b0;
        end else if (busy_q) begin
            if (pre_q == '0) begin
                pre_d = reload_b_q;
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                pre_d = pre_q - PRE_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            int_en_q   <= 1'b0;
            intr_q     <= 1'b0;
            reload_a_q <= '0;
            reload_b_q <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            dout_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            int_en_q   <= int_en_d;
            intr_q     <= intr_d;
            reload_a_q <= reload_a_d;
            reload_b_q <= reload_b_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            dout_q     <= dout_d;
        end
    end

    assign bus.bs_dout = dout_q;
    assign intr        = intr_q;

endmodule

// File: tb/tb_nova_io_pio_timer.sv
// Bench for the PIO interval timer: behavioural model, per-cycle compare, directed + random traffic.
module tb_nova_io_pio_timer;
    import nova_io_pio_timer_pkg::*;

    localparam logic [5:0] OUR = 6'o21;
    localparam logic [5:0] OTHER = 6'o22;

    logic pclk = 1'b0;
    logic prst = 1'b0;
    logic intr;

    nova_io_pio_timer_if bus();

    nova_io_pio_timer #(.DEV_CODE(6'o21), .CNT_W(16), .PRE_W(16)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus.slave),
        .intr (intr)
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the timer as seen from the bus.
    bit          m_busy, m_done, m_ie, m_intr;
    int unsigned m_ra, m_rb, m_cnt, m_pre, m_dout;
    bit          mh;
    int unsigned msel, mctl, mdin;

    always @(posedge pclk or negedge prst) begin
        if (!prst) begin
            m_busy = 0; m_done = 0; m_ie = 0; m_intr = 0;
            m_ra = 0; m_rb = 0; m_cnt = 0; m_pre = 0; m_dout = 0;
        end else begin
            mh   = bus.bs_stb && (bus.bs_adr[0:5] == OUR);
            msel = int'(bus.bs_adr[6:7]);
            mdin = int'(bus.bs_din);
            mctl = mdin % 4;
            m_intr = m_done && m_ie;
            m_dout = 0;
            if (mh && !bus.bs_we) begin
                case (msel)
                    0: m_dout = 2 * m_busy + m_done;
                    1: m_dout = m_cnt;
                    2: m_dout = m_pre;
                    default: m_dout = 4 * m_ie + 2 * m_busy + m_done;
                endcase
            end
            if (mh && bus.bs_we && msel == 0 && mctl != 0) begin
                if (mctl == 1) begin
                    m_cnt = m_ra; m_pre = m_rb; m_busy = 1; m_done = 0;
                end else if (mctl == 2) begin
                    m_busy = 0; m_done = 0;
                end else begin
                    m_done = 0;
                end
            end else if (m_busy) begin
                if (m_pre > 0) m_pre = m_pre - 1;
                else begin
                    m_pre = m_rb;
                    if (m_cnt == 1) begin
                        m_cnt = 0; m_busy = 0; m_done = 1;
                    end else begin
                        m_cnt = (m_cnt + 65535) % 65536;
                    end
                end
            end
            if (mh && bus.bs_we && msel == 1) m_ra = mdin;
            if (mh && bus.bs_we && msel == 2) m_rb = mdin;
            if (mh && bus.bs_we && msel == 3) m_ie = mdin[0];
        end
    end

    // Per-cycle compare of bus outputs against the model.
    always @(negedge pclk) begin
        n_vec++;
        if (bus.bs_dout !== 16'(m_dout) || intr !== m_intr) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t dout=%h want %h intr=%b want %b",
                     $time, bus.bs_dout, 16'(m_dout), intr, m_intr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit stb, input bit we, input logic [5:0] code,
                       input logic [1:0] sel, input logic [15:0] din, output logic [15:0] rsp);
        bus.bs_stb = stb;
        bus.bs_we  = we;
        bus.bs_adr = {code, sel};
        bus.bs_din = din;
        @(posedge pclk);
        #1;
        rsp = bus.bs_dout;
        bus.bs_stb = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] din);
        logic [15:0] r;
        cyc(1'b1, 1'b1, OUR, sel, din, r);
    endtask

    task automatic rd(input logic [1:0] sel, output logic [15:0] v);
        cyc(1'b1, 1'b0, OUR, sel, 16'h0, v);
    endtask

    task automatic idle(input int n);
        logic [15:0] r;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, OUR, 2'b00, 16'h0, r);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        bus.bs_stb = 0; bus.bs_we = 0; bus.bs_adr = '0; bus.bs_din = '0;
        repeat (3) @(posedge pclk);
        #1 prst = 1'b1;

        rd(2'b00, v); chk("reset_flag", v, 16'h0000);
        rd(2'b11, v); chk("reset_dic", v, 16'h0000);

        // 3 ticks, prescale 1 -> ticks every 2 cycles, done 6 cycles after START.
        wr(2'b01, 16'h0003); wr(2'b10, 16'h0001); wr(2'b00, 16'h0001);
        rd(2'b01, v); chk("dia_c1", v, 3);
        rd(2'b01, v); chk("dia_c2", v, 3);
        rd(2'b01, v); chk("dia_c3", v, 2);
        rd(2'b01, v); chk("dia_c4", v, 2);
        rd(2'b01, v); chk("dia_c5", v, 1);
        rd(2'b01, v); chk("dia_c6_terminal", v, 1);
        rd(2'b00, v); chk("flag_done", v, 16'h0001);

        // START in the terminal-tick cycle wins.
        wr(2'b01, 16'h0002); wr(2'b10, 16'h0000); wr(2'b00, 16'h0001);
        idle(1);
        wr(2'b00, 16'h0001);
        rd(2'b01, v); chk("restart_cnt", v, 2);
        rd(2'b00, v); chk("restart_busy", v, 16'h0002);
        rd(2'b00, v); chk("restart_done", v, 16'h0001);

        // Interrupt rises one cycle after done; PULSE drops it.
        wr(2'b11, 16'h0001); wr(2'b00, 16'h0001);
        idle(2); chk("intr_lag", intr, 0);
        idle(1); chk("intr_set", intr, 1);
        wr(2'b00, 16'h0003);
        idle(1); chk("intr_clr", intr, 0);
        rd(2'b00, v); chk("pulse_flag", v, 16'h0000);
        rd(2'b11, v); chk("dic_ie", v, 16'h0004);
        wr(2'b11, 16'h0000);

        // PULSE while running leaves busy set.
        wr(2'b01, 16'h0005); wr(2'b10, 16'h0002); wr(2'b00, 16'h0001);
        idle(1); wr(2'b00, 16'h0003);
        rd(2'b00, v); chk("pulse_busy", v, 16'h0002);
        wr(2'b00, 16'h0002);

        // Foreign device code: no effect, no data.
        cyc(1'b1, 1'b1, OTHER, 2'b01, 16'h1234, v); chk("other_wr_dout", v, 0);
        cyc(1'b1, 1'b0, OTHER, 2'b11, 16'h0, v); chk("other_rd_dout", v, 0);
        wr(2'b00, 16'h0001);
        rd(2'b01, v); chk("other_no_reload", v, 5);
        wr(2'b00, 16'h0002);

        // Reload write while busy affects only the next START; CLEAR freezes cnt.
        wr(2'b01, 16'h0007); wr(2'b10, 16'h0000); wr(2'b00, 16'h0001);
        wr(2'b01, 16'h0010);
        idle(8);
        rd(2'b00, v); chk("busy_reload_done", v, 16'h0001);
        rd(2'b01, v); chk("busy_reload_cnt0", v, 0);
        wr(2'b00, 16'h0001);
        rd(2'b01, v); chk("new_reload", v, 16'h0010);
        idle(2);
        wr(2'b00, 16'h0002);
        rd(2'b01, v); chk("clear_frozen1", v, 16'h000D);
        idle(2);
        rd(2'b01, v); chk("clear_frozen2", v, 16'h000D);
        rd(2'b00, v); chk("clear_flag", v, 16'h0000);

        // Asynchronous reset mid-count.
        wr(2'b01, 16'h0005); wr(2'b10, 16'h0003); wr(2'b11, 16'h0001); wr(2'b00, 16'h0001);
        rd(2'b01, v); chk("pre_reset_cnt", v, 5);
        prst = 1'b0;
        #1;
        chk("async_rst_dout", bus.bs_dout, 0);
        chk("async_rst_intr", intr, 0);
        @(posedge pclk); #1 prst = 1'b1;
        rd(2'b00, v); chk("post_rst_flag", v, 0);
        rd(2'b01, v); chk("post_rst_cnt", v, 0);

        // Random traffic with small reload values.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0]  code;
            logic [1:0]  sel;
            logic [15:0] din;
            bit          we;
            code = ($urandom_range(0, 9) == 0) ? OTHER : OUR;
            sel  = 2'($urandom_range(0, 3));
            we   = 1'($urandom_range(0, 1));
            din  = 16'($urandom);
            if (we && (sel == 2'b01 || sel == 2'b10)) din = 16'($urandom_range(0, 4));
            if (we && sel == 2'b00 && $urandom_range(0, 3) != 0) din = 16'h0001;
            cyc($urandom_range(0, 3) != 0, we, code, sel, din, v);
        end
        wr(2'b00, 16'h0002);

        // Full wrap: reload_a = 0 gives 65536 ticks.
        wr(2'b01, 16'h0000); wr(2'b10, 16'h0000); wr(2'b00, 16'h0001);
        idle(65535);
        rd(2'b00, v); chk("wrap_terminal_busy", v, 16'h0002);
        rd(2'b00, v); chk("wrap_done", v, 16'h0001);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
